// File: rtl/poly3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : poly3_pkg                                                    |
// | Description : Shared types and width helpers for the pipelined cubic       |
// |               evaluator (coefficient select encoding, full-precision       |
// |               result width).                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package poly3_pkg;

   // Coefficient select encoding used by the configuration port.
   typedef enum logic [1:0] {
      COEF_A = 2'd0,
      COEF_B = 2'd1,
      COEF_C = 2'd2,
      COEF_D = 2'd3
   } coef_sel_e;

   // Full-precision width of a*x^3 + b*x^2 + c*x + d.
   function automatic int fw(input int xw, input int cw);
      return 3 * xw + cw + 3;
   endfunction

endpackage : poly3_pkg
`default_nettype wire

// File: rtl/poly3_mac_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : poly3_mac_stage                                              |
// | Description : One Horner step o_acc = i_acc * i_x + i_k, registered, with  |
// |               its own stage-valid flop and a hold enable for stalls.       |
// | Ports       : clk, rst      clock / synchronous active-high reset          |
// |               i_en          advance enable (low = hold everything)         |
// |               i_valid       upstream sample valid                          |
// |               i_acc, i_x    accumulator and operand                        |
// |               i_k           coefficient added after the multiply           |
// |               o_valid       this stage holds a valid sample                |
// |               o_acc         registered full-precision accumulator          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module poly3_mac_stage
   import poly3_pkg::*;
#(
   parameter int AW_I = 4,   // incoming accumulator width
   parameter int XW   = 4,   // operand width
   parameter int KW   = 4,   // coefficient width
   parameter int AW_O = 9    // result width, wide enough for no truncation
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic            i_valid,
   input  logic [AW_I-1:0] i_acc,
   input  logic [XW-1:0]   i_x,
   input  logic [KW-1:0]   i_k,
   output logic            o_valid,
   output logic [AW_O-1:0] o_acc
);

   logic [AW_O-1:0] w_acc_next;
   logic            r_valid;
   logic [AW_O-1:0] r_acc;

   // Operands are widened to the result width first so the product never
   // truncates.
   assign w_acc_next = AW_O'(i_acc) * AW_O'(i_x) + AW_O'(i_k);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_acc   <= '0;
      end else if (i_en) begin
         r_valid <= i_valid;
         // The accumulator only moves on real data, so bubbles passing
         // through leave the last result in place.
         if (i_valid) begin
            r_acc <= w_acc_next;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_acc   = r_acc;

endmodule : poly3_mac_stage
`default_nettype wire

// File: rtl/poly3_eval_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : poly3_eval_pipe                                              |
// | Description : Three-stage pipelined unsigned cubic evaluator               |
// |               y = a*x^3 + b*x^2 + c*x + d (Horner), programmable           |
// |               coefficient bank, valid/ready on both sides.                 |
// | Ports       : clk, rst                 clock / sync active-high reset      |
// |               cfg_we, cfg_sel, cfg_data coefficient write port            |
// |               in_valid, in_ready, x_in  input stream                       |
// |               out_valid, out_ready      output handshake                   |
// |               y_out, ovf                result and overflow flag           |
// | Config      : POLY3_SAT_EN  defined -> y_out saturates when ovf is set,    |
// |                             undefined -> y_out wraps modulo 2^OW.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module poly3_eval_pipe
   import poly3_pkg::*;
#(
   parameter int XW = 4,
   parameter int CW = 4,
   parameter int OW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_sel,
   input  logic [CW-1:0] cfg_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] x_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] y_out,
   output logic          ovf
);

   localparam int FW = fw(XW, CW);
   localparam int W1 = XW + CW + 1;
   localparam int W2 = 2 * XW + CW + 2;

   logic [CW-1:0] r_coef_a, r_coef_b, r_coef_c, r_coef_d;
   logic [CW-1:0] r_c1, r_d1, r_d2;
   logic [XW-1:0] r_x1, r_x2;
   logic          w_stall, w_adv;
   logic          w_v1, w_v2, w_v3;
   logic [W1-1:0] w_acc1;
   logic [W2-1:0] w_acc2;
   logic [FW-1:0] w_acc3;

   // No bubble collapsing: the whole pipe freezes when the output is blocked.
   // in_ready depends only on registered state and out_ready.
   assign w_stall  = w_v3 && !out_ready;
   assign w_adv    = !w_stall;
   assign in_ready = w_adv;

   // Coefficient bank: writes are never blocked by a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_coef_a <= '0;
         r_coef_b <= '0;
         r_coef_c <= '0;
         r_coef_d <= '0;
      end else if (cfg_we) begin
         case (coef_sel_e'(cfg_sel))
            COEF_A:  r_coef_a <= cfg_data;
            COEF_B:  r_coef_b <= cfg_data;
            COEF_C:  r_coef_c <= cfg_data;
            default: r_coef_d <= cfg_data;
         endcase
      end
   end

   // c and d are snapshotted at acceptance and ride along with their sample,
   // so a later write never disturbs a sample already in flight. x follows
   // the same path since every Horner step needs it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c1 <= '0;
         r_d1 <= '0;
         r_d2 <= '0;
         r_x1 <= '0;
         r_x2 <= '0;
      end else if (w_adv) begin
         if (in_valid) begin
            r_c1 <= r_coef_c;
            r_d1 <= r_coef_d;
            r_x1 <= x_in;
         end
         if (w_v1) begin
            r_d2 <= r_d1;
            r_x2 <= r_x1;
         end
      end
   end

   // S1: a*x + b (a and b are read live at acceptance)
   poly3_mac_stage #(.AW_I(CW), .XW(XW), .KW(CW), .AW_O(W1)) u_s1 (
      .clk(clk), .rst(rst), .i_en(w_adv), .i_valid(in_valid),
      .i_acc(r_coef_a), .i_x(x_in), .i_k(r_coef_b),
      .o_valid(w_v1), .o_acc(w_acc1)
   );

   // S2: p1*x + c
   poly3_mac_stage #(.AW_I(W1), .XW(XW), .KW(CW), .AW_O(W2)) u_s2 (
      .clk(clk), .rst(rst), .i_en(w_adv), .i_valid(w_v1),
      .i_acc(w_acc1), .i_x(r_x1), .i_k(r_c1),
      .o_valid(w_v2), .o_acc(w_acc2)
   );

   // S3: p2*x + d, this is the output register
   poly3_mac_stage #(.AW_I(W2), .XW(XW), .KW(CW), .AW_O(FW)) u_s3 (
      .clk(clk), .rst(rst), .i_en(w_adv), .i_valid(w_v2),
      .i_acc(w_acc2), .i_x(r_x2), .i_k(r_d2),
      .o_valid(w_v3), .o_acc(w_acc3)
   );

   assign out_valid = w_v3;

   generate
      if (OW < FW) begin : g_narrow
         logic w_ovf;
         assign w_ovf = |w_acc3[FW-1:OW];
         assign ovf   = w_ovf;
`ifdef POLY3_SAT_EN
         assign y_out = w_ovf ? {OW{1'b1}} : w_acc3[OW-1:0];
`else
         assign y_out = w_acc3[OW-1:0];
`endif
      end else begin : g_wide
         // Full precision fits: never overflows, zero-extend when wider.
         assign ovf   = 1'b0;
         assign y_out = OW'(w_acc3);
      end
   endgenerate

endmodule : poly3_eval_pipe
`default_nettype wire

// File: tb/tb_poly3_eval_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_poly3_eval_pipe                                           |
// | Description : Self-checking bench for poly3_eval_pipe. Three instances     |
// |               (OW=16, 12, 24) share stimulus; a queue-based polynomial     |
// |               model predicts every result in order.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_poly3_eval_pipe;

   logic       clk;
   logic       rst;
   logic       cfg_we;
   logic [1:0] cfg_sel;
   logic [3:0] cfg_data;
   logic       in_valid;
   logic [3:0] x_in;
   logic       out_ready;

   logic        in_ready,   out_valid,   ovf;
   logic [15:0] y_out;
   logic        in_ready12, out_valid12, ovf12;
   logic [11:0] y_out12;
   logic        in_ready24, out_valid24, ovf24;
   logic [23:0] y_out24;

   int n_checks = 0;
   int n_errors = 0;
   int q[$];
   int sh[4];

   poly3_eval_pipe #(.XW(4), .CW(4), .OW(16)) u_dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .ovf(ovf)
   );

   poly3_eval_pipe #(.XW(4), .CW(4), .OW(12)) u_dut12 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready12), .x_in(x_in),
      .out_valid(out_valid12), .out_ready(out_ready), .y_out(y_out12), .ovf(ovf12)
   );

   poly3_eval_pipe #(.XW(4), .CW(4), .OW(24)) u_dut24 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready24), .x_in(x_in),
      .out_valid(out_valid24), .out_ready(out_ready), .y_out(y_out24), .ovf(ovf24)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int poly(input int a, input int b, input int c, input int d, input int x);
      return a * x * x * x + b * x * x + c * x + d;
   endfunction

   // Scoreboard: watches both handshakes between edges and predicts results.
   always @(negedge clk) begin
      int e;
      int e12;
      if (rst) begin
         q.delete();
         foreach (sh[i]) sh[i] = 0;
      end else begin
         if (out_valid) begin
            chk("out_has_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               e = q[0];
               if (e > 4095) begin
`ifdef POLY3_SAT_EN
                  e12 = 4095;
`else
                  e12 = e % 4096;
`endif
               end else begin
                  e12 = e;
               end
               chk("y16", 32'(y_out), 32'(e % 65536));
               chk("ovf16", 32'(ovf), 32'(e > 65535));
               chk("valid12", 32'(out_valid12), 32'd1);
               chk("y12", 32'(y_out12), 32'(e12));
               chk("ovf12", 32'(ovf12), 32'(e > 4095));
               chk("valid24", 32'(out_valid24), 32'd1);
               chk("y24", 32'(y_out24), 32'(e));
               chk("ovf24", 32'(ovf24), 32'd0);
               chk("in_ready_busy", 32'(in_ready), 32'(out_ready));
               if (out_ready) void'(q.pop_front());
            end
         end else begin
            chk("in_ready_idle", 32'(in_ready), 32'd1);
         end
         if (in_valid && in_ready)
            q.push_back(poly(sh[0], sh[1], sh[2], sh[3], int'(x_in)));
         if (cfg_we) sh[cfg_sel] = int'(cfg_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input int sel, input int val);
      cfg_we   = 1'b1;
      cfg_sel  = 2'(sel);
      cfg_data = 4'(val);
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic send_stream(input int xs[$], output int cycles);
      int   i;
      logic fired;
      i      = 0;
      cycles = 0;
      while (i < xs.size() && cycles < 500) begin
         in_valid = 1'b1;
         x_in     = 4'(xs[i]);
         @(negedge clk);
         fired = in_ready;
         tick();
         cycles++;
         if (fired) i++;
      end
      in_valid = 1'b0;
      if (i < xs.size()) chk("send_timeout", 32'(i), 32'(xs.size()));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int xs[$];
      int cyc, lat, nval, first, last;
      logic ovv[25];

      rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 4'd0;
      in_valid = 1'b0; x_in = 4'd0; out_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y_out", 32'(y_out), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      tick();

      // Single beat, latency: presented in cycle 0, visible in cycle 3.
      write_cfg(0, 1); write_cfg(1, 0); write_cfg(2, 0); write_cfg(3, 3);
      in_valid = 1'b1; x_in = 4'd2;
      @(negedge clk);
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
      end
      chk("t1_latency", 32'(lat), 32'd3);
      chk("t1_y", 32'(y_out), 32'd11);
      tick(); tick();

      // Full-rate stream, all coefficients 15.
      for (int s = 0; s < 4; s++) write_cfg(s, 15);
      xs.delete();
      for (int v = 0; v < 16; v++) xs.push_back(v);
      fork
         send_stream(xs, cyc);
         for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            ovv[k] = out_valid;
         end
      join
      chk("t2_in_cycles", 32'(cyc), 32'd16);
      nval = 0; first = -1; last = -1;
      for (int k = 0; k < 25; k++) begin
         if (ovv[k]) begin
            nval++;
            if (first < 0) first = k;
            last = k;
         end
      end
      chk("t2_out_count", 32'(nval), 32'd16);
      chk("t2_no_bubbles", 32'(last - first + 1), 32'd16);
      tick(); tick();

      // Backpressure mid-stream.
      for (int s = 0; s < 4; s++) write_cfg(s, $urandom_range(0, 15));
      xs.delete();
      for (int v = 1; v <= 8; v++) xs.push_back(v);
      fork
         send_stream(xs, cyc);
         begin
            lat = 0;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               if (out_valid) begin lat = 1; break; end
            end
            chk("t3_saw_output", 32'(lat), 32'd1);
            tick();
            out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk("t3_stall_in_ready", 32'(in_ready), 32'd0);
            end
            tick();
            out_ready = 1'b1;
         end
      join
      repeat (8) tick();

      // Coefficient write timing relative to acceptance.
      write_cfg(0, $urandom_range(0, 15));
      write_cfg(1, $urandom_range(0, 15));
      write_cfg(2, $urandom_range(0, 15));
      write_cfg(3, 0);
      in_valid = 1'b1; x_in = 4'd3;
      tick();
      cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 4'd7;
      tick();
      cfg_we = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();

      // Reset with a full, stalled pipe.
      write_cfg(0, 9); write_cfg(3, 5);
      out_ready = 1'b0;
      xs.delete();
      xs.push_back(4); xs.push_back(5); xs.push_back(6);
      send_stream(xs, cyc);
      chk("t6_fill_cycles", 32'(cyc), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_y_out", 32'(y_out), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b1; x_in = 4'd5;
      tick();
      in_valid = 1'b0;
      lat = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = 1; break; end
      end
      chk("t6_result_seen", 32'(lat), 32'd1);
      chk("t6_y_zero_coefs", 32'(y_out), 32'd0);
      tick(); tick();

      // Randomised traffic with live reconfiguration.
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom % 4) != 0;
         x_in      = 4'($urandom);
         out_ready = ($urandom % 3) != 0;
         cfg_we    = ($urandom % 8) == 0;
         cfg_sel   = 2'($urandom);
         cfg_data  = 4'($urandom);
         tick();
      end
      cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_poly3_eval_pipe
`default_nettype wire
